// File: rtl/round_rr_sched.sv
// Round-robin scheduler sharing one convergent-rounding stage between N_CH requesters, with tagged output FIFO.
// Latency: accept in cycle N -> o_vld in cycle N+2 (empty FIFO); 1 word/cycle sustained with i_rdy=1.
// Backpressure: accepts only while FIFO occupancy plus in-flight stage-1 word leaves room; o_rdy never looks at i_rdy.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_data  [N_CH*W_IN] channel c word at bits [c*W_IN +: W_IN], two's complement
//   i_vld   [N_CH]      per-channel request; o_rdy [N_CH] per-channel accept (one-hot or zero)
//   o_data  [W_OUT]     rounded word at FIFO head; o_ch [CH_W] its channel tag
//   o_vld               FIFO non-empty; i_rdy downstream ready (pop on o_vld & i_rdy)
module round_rr_sched #(
  parameter int N_CH       = 4,
  parameter int W_IN       = 32,
  parameter int W_OUT      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SAT        = 1,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*W_IN-1:0]   i_data,
  input  logic [N_CH-1:0]        i_vld,
  output logic [N_CH-1:0]        o_rdy,
  output logic [W_OUT-1:0]       o_data,
  output logic [CH_W-1:0]        o_ch,
  output logic                   o_vld,
  input  logic                   i_rdy
);

  localparam int K  = W_IN - W_OUT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [W_IN-1:0] HALF    = W_IN'(1) << (K - 1);
  localparam logic [W_IN-1:0] HALF_M1 = HALF - W_IN'(1);
  localparam logic [W_OUT-1:0] MAX_POS = {1'b0, {(W_OUT-1){1'b1}}};

  // Arbiter / stage-1 state
  logic [CH_W-1:0]  r_ptr;
  logic             r_s1_vld;
  logic [W_OUT-1:0] r_s1_data;
  logic [CH_W-1:0]  r_s1_ch;

  // Output FIFO state
  logic [W_OUT-1:0] r_mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]  r_mem_ch   [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_can_issue;
  logic             w_gnt_hit;
  logic [CH_W-1:0]  w_gnt_idx;
  logic [CH_W-1:0]  w_scan_idx;
  logic [N_CH-1:0]  w_onehot;
  logic             w_accept;
  logic [W_IN-1:0]  w_word;
  logic [W_IN-1:0]  w_add;
  logic [W_OUT-1:0] w_hi;
  logic             w_ovf;
  logic [W_OUT-1:0] w_rounded;
  logic             w_push;
  logic             w_pop;

  // Credit counts only registered occupancy: a pop in this cycle does not free a slot until next cycle.
  assign w_can_issue = (r_count + CW'(r_s1_vld)) < CW'(FIFO_DEPTH);

  // Scan from the channel after the last winner, wrapping, so a held request waits at most N_CH-1 accepts.
  always_comb begin
    w_gnt_hit  = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_scan_idx = CH_W'((int'(r_ptr) + i) % N_CH);
      if (!w_gnt_hit && i_vld[w_scan_idx]) begin
        w_gnt_hit = 1'b1;
        w_gnt_idx = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    if (w_gnt_hit) w_onehot[w_gnt_idx] = 1'b1;
  end

  // rst_n gating keeps o_rdy low while reset is asserted even though the arbiter is combinational.
  assign o_rdy    = w_onehot & {N_CH{w_can_issue & rst_n}};
  assign w_accept = |o_rdy;

  always_comb begin
    w_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_gnt_idx == CH_W'(c)) w_word = i_data[c*W_IN +: W_IN];
    end
  end

  // Round half to even: when the kept LSB is 1 an exact half carries up, when it is 0 it does not.
  assign w_add = w_word[K] ? HALF : HALF_M1;
  assign w_hi  = W_OUT'((w_word + w_add) >> K);
  // Only a non-negative input can carry into the sign bit; negatives never overflow.
  assign w_ovf = ~w_word[W_IN-1] & w_hi[W_OUT-1];
  assign w_rounded = (w_ovf && (SAT != 0)) ? MAX_POS : w_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= CH_W'(N_CH - 1);
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_ch   <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_ptr     <= w_gnt_idx;
        r_s1_data <= w_rounded;
        r_s1_ch   <= w_gnt_idx;
      end
    end
  end

  assign w_push = r_s1_vld;
  assign w_pop  = o_vld & i_rdy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= r_s1_data;
      r_mem_ch[r_wr_ptr]   <= r_s1_ch;
    end
  end

  // Credit guarantees push never meets a full FIFO without a matching pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_vld  = (r_count != '0);
  assign o_data = r_mem_data[r_rd_ptr];
  assign o_ch   = r_mem_ch[r_rd_ptr];

endmodule

// File: tb/tb_round_rr_sched.sv
// Testbench for round_rr_sched: directed rounding vectors, arbitration order, backpressure,
// randomized traffic against a behavioural grant/credit/rounding model, and mid-run reset.
module tb_round_rr_sched;
  localparam int N_CH  = 4;
  localparam int W_IN  = 32;
  localparam int W_OUT = 16;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_CH*W_IN-1:0] i_data;
  logic [N_CH-1:0]      i_vld;
  logic                 i_rdy;
  logic [N_CH-1:0]      o_rdy, o_rdy_w;
  logic [W_OUT-1:0]     o_data, o_data_w;
  logic [1:0]           o_ch, o_ch_w;
  logic                 o_vld, o_vld_w;

  always #5 clk = ~clk;

  round_rr_sched #(.N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT), .FIFO_DEPTH(DEPTH), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy),
    .o_data(o_data), .o_ch(o_ch), .o_vld(o_vld), .i_rdy(i_rdy));

  // Wrapping variant sees identical stimulus; only its rounded data is inspected.
  round_rr_sched #(.N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT), .FIFO_DEPTH(DEPTH), .SAT(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy_w),
    .o_data(o_data_w), .o_ch(o_ch_w), .o_vld(o_vld_w), .i_rdy(i_rdy));

  typedef struct { int ch; logic [15:0] data; } item_t;
  item_t exp_q[$];
  item_t got_q[$];
  int    n_acc = 0, n_pop = 0, last_grant = N_CH - 1;
  int    chk_cnt = 0, pass_cnt = 0;

  localparam int          NV = 6;
  localparam int          VC [NV] = '{0, 0, 0, 0, 1, 1};
  localparam logic [31:0] VX [NV] = '{32'h0001_8000, 32'h0002_8000, 32'h0002_8001,
                                      32'hFFFF_8000, 32'h7FFF_8000, 32'h8000_0000};
  localparam logic [15:0] VS [NV] = '{16'h0002, 16'h0002, 16'h0003, 16'h0000, 16'h7FFF, 16'h8000};
  localparam logic [15:0] VW [NV] = '{16'h0002, 16'h0002, 16'h0003, 16'h0000, 16'h8000, 16'h8000};

  // Reference rounding: nearest integer of x/2^16, ties to even, then clamp or wrap to 16 bits.
  function automatic logic [15:0] ref_round(logic [31:0] x, bit sat);
    longint xs, q, r;
    xs = longint'($signed(x));
    q  = xs >>> 16;
    r  = xs - q * 65536;
    if (r > 32768 || (r == 32768 && (q % 2) != 0)) q = q + 1;
    if (q > 32767) q = sat ? 32767 : q - 65536;
    return 16'(q);
  endfunction

  // Reference grant: first valid requester after the previous winner, only when occupancy leaves room.
  function automatic logic [N_CH-1:0] ref_grant(logic [N_CH-1:0] vld, int last, int outstanding);
    if (outstanding >= DEPTH) return '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (vld[(last + i) % N_CH]) return N_CH'(1) << ((last + i) % N_CH);
    end
    return '0;
  endfunction

  function automatic int q_errors();
    int e;
    e = (exp_q.size() != got_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (exp_q[i].ch != got_q[i].ch || exp_q[i].data !== got_q[i].data) e++;
    return e;
  endfunction

  // Log handshakes just before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_vld[c] && o_rdy[c]) begin
          exp_q.push_back('{c, ref_round(i_data[c*W_IN +: W_IN], 1'b1)});
          n_acc++;
          last_grant = c;
        end
      end
      if (o_vld && i_rdy) begin
        got_q.push_back('{int'(o_ch), o_data});
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    logic [31:0] x;
    for (int c = 0; c < N_CH; c++) begin
      x = $urandom;
      if ($urandom_range(0, 3) == 0) x[15:0] = 16'h8000;
      if ($urandom_range(0, 7) == 0) x[31:16] = 16'h7FFF;
      i_data[c*W_IN +: W_IN] = x;
    end
  endtask

  task automatic drain(output bit ok);
    i_vld = '0;
    i_rdy = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (n_pop == n_acc && !o_vld) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_vld = '1; i_rdy = 1'b1; i_data = '0;
    #1;
    chk_cnt++; if (o_vld !== 1'b0) $display("FAIL reset_o_vld got=%b want=0", o_vld); else pass_cnt++;
    chk_cnt++; if (o_rdy !== 4'b0000) $display("FAIL reset_o_rdy got=%b want=0000", o_rdy); else pass_cnt++;
    tick(); tick();
    i_vld = '0;
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (o_vld !== 1'b0) $display("FAIL post_reset_o_vld got=%b want=0", o_vld); else pass_cnt++;
  endtask

  task automatic test_rounding();
    i_rdy = 1'b1;
    for (int v = 0; v < NV; v++) begin
      i_data = '0;
      i_data[VC[v]*W_IN +: W_IN] = VX[v];
      i_vld = N_CH'(1) << VC[v];
      #1;
      chk_cnt++; if (o_rdy !== (N_CH'(1) << VC[v])) $display("FAIL round_grant v=%0d got=%b want=%b", v, o_rdy, N_CH'(1) << VC[v]); else pass_cnt++;
      tick();
      i_vld = '0;
      chk_cnt++; if (o_vld !== 1'b0) $display("FAIL round_lat_n1 v=%0d got o_vld=%b want=0", v, o_vld); else pass_cnt++;
      tick();
      chk_cnt++; if (o_vld !== 1'b1) $display("FAIL round_lat_n2 v=%0d got o_vld=%b want=1", v, o_vld); else pass_cnt++;
      chk_cnt++; if (o_data !== VS[v] || int'(o_ch) != VC[v]) $display("FAIL round_sat v=%0d got=%h ch%0d want=%h ch%0d", v, o_data, o_ch, VS[v], VC[v]); else pass_cnt++;
      chk_cnt++; if (o_data_w !== VW[v]) $display("FAIL round_wrap v=%0d got=%h want=%h", v, o_data_w, VW[v]); else pass_cnt++;
      tick();
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [N_CH-1:0] eg;
    drain(ok);
    exp_q.delete(); got_q.delete();
    i_vld = '1;
    for (int k = 0; k < 16; k++) begin
      rand_data();
      #1;
      eg = ref_grant(i_vld, last_grant, n_acc - n_pop);
      chk_cnt++; if (o_rdy !== eg) $display("FAIL rr_grant k=%0d got=%b want=%b", k, o_rdy, eg); else pass_cnt++;
      if (k >= 2) begin
        chk_cnt++; if (o_vld !== 1'b1) $display("FAIL rr_no_gap k=%0d got o_vld=%b want=1", k, o_vld); else pass_cnt++;
      end
      tick();
    end
    drain(ok);
    chk_cnt++; if (!ok) $display("FAIL rr_drain timeout acc=%0d pop=%0d", n_acc, n_pop); else pass_cnt++;
    chk_cnt++; if (q_errors() != 0 || exp_q.size() != 16) $display("FAIL rr_order errors=%0d got=%0d want=16 words", q_errors(), got_q.size()); else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] held;
    logic [N_CH-1:0] eg;
    drain(ok);
    exp_q.delete(); got_q.delete();
    held = '0;
    i_rdy = 1'b0;
    i_vld = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      #1;
      eg = (k < DEPTH) ? 4'b0100 : 4'b0000;
      chk_cnt++; if (o_rdy !== eg) $display("FAIL bp_credit k=%0d got=%b want=%b", k, o_rdy, eg); else pass_cnt++;
      if (k == 8) held = o_data;
      if (k == 9) begin
        chk_cnt++; if (o_data !== held) $display("FAIL bp_stable got=%h want=%h", o_data, held); else pass_cnt++;
      end
      tick();
    end
    drain(ok);
    chk_cnt++; if (!ok) $display("FAIL bp_drain timeout acc=%0d pop=%0d", n_acc, n_pop); else pass_cnt++;
    chk_cnt++; if (q_errors() != 0 || got_q.size() != DEPTH) $display("FAIL bp_order errors=%0d got=%0d want=%0d words", q_errors(), got_q.size(), DEPTH); else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_pointer();
    bit ok;
    logic [N_CH-1:0] vm [7];
    logic [N_CH-1:0] gm [7];
    vm = '{4'b1000, 4'b0010, 4'b1000, 4'b0011, 4'b0011, 4'b1010, 4'b0101};
    gm = '{4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    drain(ok);
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 7; k++) begin
      rand_data();
      i_vld = vm[k];
      #1;
      chk_cnt++; if (o_rdy !== gm[k]) $display("FAIL ptr_step k=%0d vld=%b got=%b want=%b", k, vm[k], o_rdy, gm[k]); else pass_cnt++;
      tick();
    end
    drain(ok);
    chk_cnt++; if (!ok || q_errors() != 0) $display("FAIL ptr_order drained=%0d errors=%0d", ok, q_errors()); else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [N_CH-1:0] eg;
    int errs;
    drain(ok);
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 400; k++) begin
      rand_data();
      i_vld = N_CH'($urandom_range(0, 15));
      i_rdy = ($urandom_range(0, 3) != 0);
      #1;
      eg = ref_grant(i_vld, last_grant, n_acc - n_pop);
      chk_cnt++; if (o_rdy !== eg) $display("FAIL rand_grant k=%0d vld=%b got=%b want=%b", k, i_vld, o_rdy, eg); else pass_cnt++;
      tick();
    end
    drain(ok);
    chk_cnt++; if (!ok) $display("FAIL rand_drain timeout acc=%0d pop=%0d", n_acc, n_pop); else pass_cnt++;
    errs = q_errors();
    chk_cnt++; if (errs != 0) $display("FAIL rand_scoreboard errors=%0d got=%0d want=%0d words", errs, got_q.size(), exp_q.size()); else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    drain(ok);
    exp_q.delete(); got_q.delete();
    i_rdy = 1'b0;
    i_vld = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      tick();
    end
    i_vld = '0;
    tick();
    chk_cnt++; if (o_vld !== 1'b1) $display("FAIL mid_prefill got o_vld=%b want=1", o_vld); else pass_cnt++;
    rst_n = 1'b0;
    i_vld = '1;
    #1;
    chk_cnt++; if (o_vld !== 1'b0) $display("FAIL mid_async_o_vld got=%b want=0", o_vld); else pass_cnt++;
    chk_cnt++; if (o_rdy !== 4'b0000) $display("FAIL mid_async_o_rdy got=%b want=0000", o_rdy); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    n_acc = 0; n_pop = 0; last_grant = N_CH - 1;
    i_rdy = 1'b1;
    rand_data();
    #1;
    chk_cnt++; if (o_vld !== 1'b0) $display("FAIL mid_no_stale got o_vld=%b want=0", o_vld); else pass_cnt++;
    chk_cnt++; if (o_rdy !== 4'b0001) $display("FAIL mid_first_grant got=%b want=0001", o_rdy); else pass_cnt++;
    tick();
    i_vld = '0;
    drain(ok);
    chk_cnt++; if (!ok || q_errors() != 0 || got_q.size() != 1 || got_q[0].ch != 0)
      $display("FAIL mid_after_release drained=%0d errors=%0d got=%0d want=1 word from ch0", ok, q_errors(), got_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rounding();
    test_round_robin();
    test_backpressure();
    test_pointer();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
